// File: rtl/regbank_pkg.sv
// Shared types and the write-merge helper for the register bank.
// REGBANK_FORWARD_EN (optional): same-edge write-to-read forwarding.
package regbank_pkg;

    localparam int MAX_W = 64;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    typedef enum logic [1:0] {
        WSEL_MEM,
        WSEL_HIGH,
        WSEL_FULL
    } wsel_t;

    typedef logic [MAX_W-1:0] word_t;

    // Words are zero-extended to MAX_W; caller truncates the result.
    function automatic word_t merge_word(
        input wsel_t       sel,
        input word_t       old_w,
        input word_t       data_d,
        input word_t       mem_q,
        input int unsigned half
    );
        word_t lo_mask;
        word_t res;
        lo_mask = {MAX_W{1'b1}} >> (MAX_W - half);
        case (sel)
            WSEL_MEM:  res = mem_q;
            WSEL_HIGH: res = (old_w & lo_mask)
                           | ((data_d & lo_mask) << half);
            default:   res = data_d;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/regbank_clear_seq.sv
// Post-reset clear sweep: walks registers 1..REG_COUNT-1 writing zero.
// REGBANK_FORWARD_EN does not affect this block.
module regbank_clear_seq
    import regbank_pkg::*;
#(
    parameter int REG_COUNT = 16,
    parameter int ADDR_W    = $clog2(REG_COUNT)
) (
    input  logic              clk,
    input  logic              reset,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_nx;
    logic              last;

    assign last = (idx == ADDR_W'(REG_COUNT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
            idx   <= ADDR_W'(1);
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        if (state == CLEAR) begin
            idx_nx = idx + ADDR_W'(1);
            if (last) begin
                state_nx = RUN;
            end
        end
    end

    always_comb begin
        busy     = (state == CLEAR);
        clr_we   = (state == CLEAR);
        clr_addr = idx;
    end

endmodule

// File: rtl/regbank_param.sv
// Two-read/one-write CPU register bank with post-reset clear sweep.
// REGBANK_FORWARD_EN: reads on a write edge return the new value.
module regbank_param
    import regbank_pkg::*;
#(
    parameter  int DATA_W    = 32,
    parameter  int REG_COUNT = 16,
    localparam int ADDR_W    = $clog2(REG_COUNT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              get_regs,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    output logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] data_b,
    input  logic              write_back,
    input  logic              we,
    input  logic              we_high,
    input  logic [ADDR_W-1:0] addr_d,
    input  logic [DATA_W-1:0] data_d,
    input  logic              read_mem,
    input  logic [DATA_W-1:0] mem_q,
    output logic              busy
);

    localparam int unsigned HALF = DATA_W / 2;

    logic [DATA_W-1:0] regs [REG_COUNT];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              port_we;
    wsel_t             wsel;
    logic [DATA_W-1:0] new_word;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic [ADDR_W-1:0] ra_q;
    logic [ADDR_W-1:0] rb_q;
    logic [DATA_W-1:0] da_q;
    logic [DATA_W-1:0] db_q;

    regbank_clear_seq #(
        .REG_COUNT (REG_COUNT),
        .ADDR_W    (ADDR_W)
    ) u_clear (
        .clk      (clk),
        .reset    (reset),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign port_we = write_back & we & ~busy & ~reset
                   & (addr_d != '0);

    always_comb begin
        wsel = WSEL_FULL;
        if (read_mem) begin
            wsel = WSEL_MEM;
        end else if (we_high) begin
            wsel = WSEL_HIGH;
        end
    end

    assign new_word = DATA_W'(merge_word(
        wsel,
        word_t'(regs[addr_d]),
        word_t'(data_d),
        word_t'(mem_q),
        HALF
    ));

    // The sweep owns the write port while it runs.
    always_comb begin
        wr_en   = clr_we | port_we;
        wr_addr = clr_we ? clr_addr : addr_d;
        wr_data = clr_we ? '0 : new_word;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_a = regs[addr_a];
        rd_b = regs[addr_b];
`ifdef REGBANK_FORWARD_EN
        if (port_we && addr_d == addr_a) begin
            rd_a = new_word;
        end
        if (port_we && addr_d == addr_b) begin
            rd_b = new_word;
        end
`endif
        if (busy) begin
            rd_a = '0;
            rd_b = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ra_q <= '0;
            rb_q <= '0;
            da_q <= '0;
            db_q <= '0;
        end else if (get_regs) begin
            ra_q <= addr_a;
            rb_q <= addr_b;
            da_q <= rd_a;
            db_q <= rd_b;
        end
    end

    assign data_a = (ra_q == '0) ? '0 : da_q;
    assign data_b = (rb_q == '0) ? '0 : db_q;

endmodule

// File: tb/tb_regbank_param.sv
// Directed plus randomized bench for regbank_param against an array model.
// Define REGBANK_FORWARD_EN here too when building the forwarding variant.
module tb_regbank_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        get_regs;
    logic [3:0]  addr_a;
    logic [3:0]  addr_b;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic        write_back;
    logic        we;
    logic        we_high;
    logic [3:0]  addr_d;
    logic [31:0] data_d;
    logic        read_mem;
    logic [31:0] mem_q;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] mreg [16];
    bit          mbusy = 1'b0;
    int          mleft = 0;
    int          mnext = 1;
    logic [31:0] ea = '0;
    logic [31:0] eb = '0;

    always #5 clk = ~clk;

    regbank_param dut (
        .clk        (clk),
        .reset      (reset),
        .get_regs   (get_regs),
        .addr_a     (addr_a),
        .addr_b     (addr_b),
        .data_a     (data_a),
        .data_b     (data_b),
        .write_back (write_back),
        .we         (we),
        .we_high    (we_high),
        .addr_d     (addr_d),
        .data_d     (data_d),
        .read_mem   (read_mem),
        .mem_q      (mem_q),
        .busy       (busy)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h",
                   tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wr_value(input int a);
        if (read_mem) return mem_q;
        if (we_high) return {data_d[15:0], mreg[a][15:0]};
        return data_d;
    endfunction

    function automatic logic [31:0] rd_value(input int a,
                                             input bit hit,
                                             input logic [31:0] nv);
        if (mbusy || a == 0) return 32'h0;
`ifdef REGBANK_FORWARD_EN
        if (hit) return nv;
`endif
        return mreg[a];
    endfunction

    // Apply one clock edge to the model, then compare at the falling edge.
    task automatic tick();
        bit          wr;
        logic [31:0] nv;
        wr = !reset && !mbusy && write_back && we && addr_d != 0;
        nv = wr_value(int'(addr_d));
        if (reset) begin
            ea = '0;
            eb = '0;
        end else if (get_regs) begin
            ea = rd_value(int'(addr_a), wr && addr_a == addr_d, nv);
            eb = rd_value(int'(addr_b), wr && addr_b == addr_d, nv);
        end
        if (wr) mreg[addr_d] = nv;
        if (mbusy) begin
            mreg[mnext] = '0;
            mnext++;
            mleft--;
            if (mleft == 0) mbusy = 1'b0;
        end
        if (reset) begin
            mbusy = 1'b1;
            mleft = 15;
            mnext = 1;
        end
        @(posedge clk);
        @(negedge clk);
        chk("data_a", data_a, ea);
        chk("data_b", data_b, eb);
        chk("busy", {31'b0, busy}, {31'b0, mbusy});
    endtask

    task automatic idle();
        get_regs   = 0;
        write_back = 0;
        we         = 0;
        we_high    = 0;
        read_mem   = 0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d,
                      input bit hi, input bit mem, input logic [31:0] mq);
        write_back = 1;
        we         = 1;
        addr_d     = a;
        data_d     = d;
        we_high    = hi;
        read_mem   = mem;
        mem_q      = mq;
        tick();
        idle();
    endtask

    task automatic rd(input logic [3:0] a, input logic [3:0] b);
        get_regs = 1;
        addr_a   = a;
        addr_b   = b;
        tick();
        idle();
    endtask

    task automatic count_busy(input string tag);
        int n;
        n = 0;
        while (busy && n < 40) begin
            n++;
            tick();
        end
        chk(tag, 32'(n), 32'd15);
    endtask

    initial begin
        foreach (mreg[i]) mreg[i] = '0;
        idle();
        addr_a = 0;
        addr_b = 0;
        addr_d = 0;
        data_d = 0;
        mem_q  = 0;
        reset  = 1;
        tick();
        reset = 0;
        chk("reset_data_a", data_a, 32'h0);
        chk("reset_busy", {31'b0, busy}, 32'h1);
        count_busy("sweep_len");

        for (int i = 1; i < 16; i++) begin
            rd(4'(i), 4'(16 - i));
            chk("clear_a", data_a, 32'h0);
        end

        wr(4'd3, 32'hDEADBEEF, 0, 0, 0);
        rd(4'd3, 4'd0);
        chk("r3_a", data_a, 32'hDEADBEEF);
        chk("r0_b", data_b, 32'h0);

        wr(4'd5, 32'h12345678, 0, 0, 0);
        wr(4'd5, 32'h0000ABCD, 1, 0, 0);
        rd(4'd5, 4'd5);
        chk("r5_high", data_a, 32'hABCD5678);

        wr(4'd7, 32'h11111111, 1, 1, 32'hCAFEF00D);
        rd(4'd0, 4'd7);
        chk("r7_mem", data_b, 32'hCAFEF00D);

        wr(4'd0, 32'h55555555, 0, 0, 0);
        rd(4'd0, 4'd0);
        chk("r0_write", data_a, 32'h0);

        get_regs = 1;
        addr_a   = 4'd2;
        addr_b   = 4'd3;
        wr(4'd2, 32'hA5A5A5A5, 0, 0, 0);
`ifdef REGBANK_FORWARD_EN
        chk("fwd_r2", data_a, 32'hA5A5A5A5);
`else
        chk("nofwd_r2", data_a, 32'h0);
`endif
        chk("fwd_other", data_b, 32'hDEADBEEF);
        rd(4'd2, 4'd2);
        chk("r2_later", data_a, 32'hA5A5A5A5);

        wr(4'd9, 32'hFFFFFFFF, 0, 0, 0);
        rd(4'd9, 4'd0);
        chk("r9_fill", data_a, 32'hFFFFFFFF);
        reset = 1;
        tick();
        reset = 0;
        repeat (5) tick();
        chk("sweep_idx6", 32'(mnext), 32'd6);
        reset      = 1;
        write_back = 1;
        we         = 1;
        addr_d     = 4'd9;
        data_d     = 32'hFFFFFFFF;
        tick();
        reset = 0;
        count_busy("resweep_len");
        idle();
        rd(4'd9, 4'd9);
        chk("r9_cleared", data_a, 32'h0);

        for (int n = 0; n < 400; n++) begin
            reset      = ($urandom_range(0, 99) == 0);
            get_regs   = 1'($urandom);
            addr_a     = 4'($urandom);
            addr_b     = 4'($urandom);
            write_back = 1'($urandom);
            we         = ($urandom_range(0, 3) != 0);
            we_high    = ($urandom_range(0, 3) == 0);
            read_mem   = ($urandom_range(0, 3) == 0);
            addr_d     = ($urandom_range(0, 1) == 0) ? addr_a
                                                     : 4'($urandom);
            data_d     = $urandom;
            mem_q      = $urandom;
            tick();
        end
        reset = 0;
        idle();
        repeat (20) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
